// File: rtl/id_ex_if.sv
// Bundle of ID-side fields, MEM/WB forwarding sources, pipeline control and the
// EX-side outputs shared by the ID/EX pipeline register and whoever drives it.
interface id_ex_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            flush_i;
  logic            id_valid_i;
  logic [XLEN-1:0] id_pc_i;
  logic [XLEN-1:0] id_rs1_data_i;
  logic [XLEN-1:0] id_rs2_data_i;
  logic [XLEN-1:0] id_imm_i;
  logic [4:0]      id_rs1_addr_i;
  logic [4:0]      id_rs2_addr_i;
  logic [4:0]      id_rd_addr_i;
  logic [3:0]      id_AluSel_i;
  logic            id_ASel_i;
  logic            id_BSel_i;
  logic            id_RegWEn_i;

  logic            mem_RegWEn_i;
  logic [4:0]      mem_rd_addr_i;
  logic [XLEN-1:0] mem_fwd_data_i;
  logic            wb_RegWEn_i;
  logic [4:0]      wb_rd_addr_i;
  logic [XLEN-1:0] wb_fwd_data_i;

  logic            ex_valid_o;
  logic [XLEN-1:0] alu_rs1_o;
  logic [XLEN-1:0] alu_rs2_o;
  logic [3:0]      AluSel_o;
  logic [XLEN-1:0] ex_store_data_o;
  logic [XLEN-1:0] ex_pc_o;
  logic [4:0]      ex_rd_addr_o;
  logic            ex_RegWEn_o;

  // The stage itself sits on the slave side.
  modport slave (
    input  stall_i, flush_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_AluSel_i,
           id_ASel_i, id_BSel_i, id_RegWEn_i,
           mem_RegWEn_i, mem_rd_addr_i, mem_fwd_data_i,
           wb_RegWEn_i, wb_rd_addr_i, wb_fwd_data_i,
    output ex_valid_o, alu_rs1_o, alu_rs2_o, AluSel_o, ex_store_data_o,
           ex_pc_o, ex_rd_addr_o, ex_RegWEn_o
  );

  modport master (
    output stall_i, flush_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_AluSel_i,
           id_ASel_i, id_BSel_i, id_RegWEn_i,
           mem_RegWEn_i, mem_rd_addr_i, mem_fwd_data_i,
           wb_RegWEn_i, wb_rd_addr_i, wb_fwd_data_i,
    input  ex_valid_o, alu_rs1_o, alu_rs2_o, AluSel_o, ex_store_data_o,
           ex_pc_o, ex_rd_addr_o, ex_RegWEn_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control and MEM/WB operand forwarding.
// Stalled operands keep re-sampling their forwarded value so late results survive.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  id_ex_if.slave   bus
);

  logic            bubble;

  logic            valid_q,  valid_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] imm_q,    imm_d;
  logic [4:0]      rd_q,     rd_d;
  logic [3:0]      alusel_q, alusel_d;
  logic            asel_q,   asel_d;
  logic            bsel_q,   bsel_d;
  logic            regwen_q, regwen_d;

  // A bubble is loaded on flush, or on a normal advance of an empty ID slot.
  assign bubble = bus.flush_i || (!bus.stall_i && !bus.id_valid_i);

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    rd_d     = rd_q;
    alusel_d = alusel_q;
    asel_d   = asel_q;
    bsel_d   = bsel_q;
    regwen_d = regwen_q;
    if (bubble) begin
      valid_d  = 1'b0;
      pc_d     = '0;
      imm_d    = '0;
      rd_d     = '0;
      alusel_d = '0;
      asel_d   = 1'b0;
      bsel_d   = 1'b0;
      regwen_d = 1'b0;
    end else if (!bus.stall_i) begin
      valid_d  = 1'b1;
      pc_d     = bus.id_pc_i;
      imm_d    = bus.id_imm_i;
      rd_d     = bus.id_rd_addr_i;
      alusel_d = bus.id_AluSel_i;
      asel_d   = bus.id_ASel_i;
      bsel_d   = bus.id_BSel_i;
      regwen_d = bus.id_RegWEn_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
      alusel_q <= '0;
      asel_q   <= 1'b0;
      bsel_q   <= 1'b0;
      regwen_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
      alusel_q <= alusel_d;
      asel_q   <= asel_d;
      bsel_q   <= bsel_d;
      regwen_q <= regwen_d;
    end
  end

  // Operand 0 is rs1, operand 1 is rs2; each has its own register and forward mux.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [XLEN-1:0] id_data;
      logic [4:0]      id_addr;
      logic [XLEN-1:0] data_q, data_d;
      logic [4:0]      addr_q, addr_d;
      logic [XLEN-1:0] fwd;

      assign id_data = (gi == 0) ? bus.id_rs1_data_i : bus.id_rs2_data_i;
      assign id_addr = (gi == 0) ? bus.id_rs1_addr_i : bus.id_rs2_addr_i;

      // MEM is the younger producer, so it wins over WB; x0 never forwards.
      always_comb begin
        fwd = data_q;
        if (addr_q != 5'd0) begin
          if (bus.mem_RegWEn_i && (bus.mem_rd_addr_i == addr_q)) begin
            fwd = bus.mem_fwd_data_i;
          end else if (bus.wb_RegWEn_i && (bus.wb_rd_addr_i == addr_q)) begin
            fwd = bus.wb_fwd_data_i;
          end
        end
      end

      always_comb begin
        data_d = data_q;
        addr_d = addr_q;
        if (bubble) begin
          data_d = '0;
          addr_d = '0;
        end else if (bus.stall_i) begin
          data_d = fwd;
        end else begin
          data_d = id_data;
          addr_d = id_addr;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          data_q <= '0;
          addr_q <= '0;
        end else begin
          data_q <= data_d;
          addr_q <= addr_d;
        end
      end
    end
  endgenerate

  assign bus.ex_valid_o      = valid_q;
  assign bus.alu_rs1_o       = asel_q ? pc_q  : g_opnd[0].fwd;
  assign bus.alu_rs2_o       = bsel_q ? imm_q : g_opnd[1].fwd;
  assign bus.ex_store_data_o = g_opnd[1].fwd;
  assign bus.AluSel_o        = alusel_q;
  assign bus.ex_pc_o         = pc_q;
  assign bus.ex_rd_addr_o    = rd_q;
  assign bus.ex_RegWEn_o     = regwen_q & valid_q;

endmodule
